// File: rtl/dd_pkg.sv
// Shared state encoding and default sizing for the FX3 transfer path.
package dd_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STREAM = 3'd1,
    FLUSH  = 3'd2,
    GAP    = 3'd3,
    HALT   = 3'd4
  } xferState_t;

  localparam int PACKET_WORDS_DEFAULT = 8192;
  localparam int READ_LATENCY_DEFAULT = 2;

endpackage

// File: rtl/read_latency_pipe.sv
// Delays the FIFO read strobe to line up with valid data on the GPIF bus.
module read_latency_pipe #(
  parameter int READ_LATENCY = 2
) (
  input  logic fx3_clock,
  input  logic nReset,
  input  logic strobeIn,
  output logic strobeOut,
  output logic pipeEmpty
);

  logic [READ_LATENCY-1:0] pipe;
  logic [READ_LATENCY-1:0] pending;

  always_ff @(posedge fx3_clock or negedge nReset) begin
    if (!nReset) begin
      pipe <= '0;
    end else begin
      pipe[0] <= strobeIn;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // Strobes still behind the output stage; zero means the pipe is empty after this edge.
  assign pending   = pipe << 1;
  assign pipeEmpty = (pending == '0);
  assign strobeOut = pipe[READ_LATENCY-1];

endmodule

// File: rtl/fx3_transfer_controller.sv
// Bursts one packet at a time from the sample FIFO to the FX3 GPIF bus,
// with abort-on-error and per-capture packet/error status.
module fx3_transfer_controller
  import dd_pkg::*;
#(
  parameter int PACKET_WORDS = PACKET_WORDS_DEFAULT,
  parameter int CNT_W        = $clog2(PACKET_WORDS),
  parameter int READ_LATENCY = READ_LATENCY_DEFAULT,
  parameter int GAP_CYCLES   = 4
) (
  input  logic        fx3_clock,
  input  logic        nReset,
  input  logic        collectData,
  input  logic        dataAvailable,
  input  logic        bufferError,
  input  logic        fx3_ready,
  output logic        readData,
  output logic        fx3_write,
  output logic        packetDone,
  output logic        streaming,
  output logic        errorLatched,
  output logic [15:0] packetCount
);

  localparam int                GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(PACKET_WORDS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  xferState_t       state;
  logic [CNT_W-1:0] wordCnt;
  logic [GAP_W-1:0] gapCnt;
  logic             collectPrev;
  logic             collectRise;
  logic             haltReq;
  logic             pipeEmpty;

  assign collectRise = collectData & ~collectPrev;
  assign haltReq     = bufferError & collectData & (state != HALT);
  assign streaming   = (state == STREAM) || (state == FLUSH);

  read_latency_pipe #(
    .READ_LATENCY(READ_LATENCY)
  ) latencyPipe (
    .fx3_clock(fx3_clock),
    .nReset   (nReset),
    .strobeIn (readData),
    .strobeOut(fx3_write),
    .pipeEmpty(pipeEmpty)
  );

  always_ff @(posedge fx3_clock or negedge nReset) begin
    if (!nReset) begin
      state        <= IDLE;
      readData     <= 1'b0;
      packetDone   <= 1'b0;
      errorLatched <= 1'b0;
      packetCount  <= '0;
      wordCnt      <= '0;
      gapCnt       <= '0;
      collectPrev  <= 1'b0;
    end else begin
      collectPrev <= collectData;
      packetDone  <= 1'b0;
      if (collectRise) begin
        packetCount  <= '0;
        errorLatched <= 1'b0;
      end
      // An abort outranks every transition, including the last-read edge.
      if (haltReq) begin
        state        <= HALT;
        readData     <= 1'b0;
        wordCnt      <= '0;
        errorLatched <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (collectData && dataAvailable && fx3_ready) begin
              state    <= STREAM;
              readData <= 1'b1;
              wordCnt  <= '0;
            end
          end
          STREAM: begin
            if (wordCnt == LAST_WORD) begin
              state    <= FLUSH;
              readData <= 1'b0;
              wordCnt  <= '0;
            end else begin
              wordCnt <= wordCnt + 1'b1;
            end
          end
          FLUSH: begin
            if (pipeEmpty) begin
              state      <= GAP;
              gapCnt     <= '0;
              packetDone <= 1'b1;
              if (!collectRise) begin
                packetCount <= packetCount + 16'd1;
              end
            end
          end
          GAP: begin
            if (gapCnt == GAP_LAST) begin
              state <= IDLE;
            end else begin
              gapCnt <= gapCnt + 1'b1;
            end
          end
          HALT: begin
            if (!collectData) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fx3_transfer_controller.sv
// Scoreboard bench: stimulus queues expected packet/abort records, a monitor checks them as they appear.
module tb_fx3_transfer_controller;

  localparam int PW  = 8192;
  localparam int LAT = 2;
  localparam int GAP = 4;

  logic        fx3_clock;
  logic        nReset;
  logic        collectData;
  logic        dataAvailable;
  logic        bufferError;
  logic        fx3_ready;
  logic        readData;
  logic        fx3_write;
  logic        packetDone;
  logic        streaming;
  logic        errorLatched;
  logic [15:0] packetCount;

  fx3_transfer_controller #(
    .PACKET_WORDS(PW),
    .CNT_W       (13),
    .READ_LATENCY(LAT),
    .GAP_CYCLES  (GAP)
  ) dut (
    .fx3_clock    (fx3_clock),
    .nReset       (nReset),
    .collectData  (collectData),
    .dataAvailable(dataAvailable),
    .bufferError  (bufferError),
    .fx3_ready    (fx3_ready),
    .readData     (readData),
    .fx3_write    (fx3_write),
    .packetDone   (packetDone),
    .streaming    (streaming),
    .errorLatched (errorLatched),
    .packetCount  (packetCount)
  );

  initial fx3_clock = 1'b0;
  always #5 fx3_clock = ~fx3_clock;

  typedef struct {
    bit isAbort;
    int words;
    int count;
  } exp_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;
  int   modelCount = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge fx3_clock);
  endtask

  task automatic pushExp(input bit isAbort, input int words, input int count);
    exp_t e;
    e.isAbort = isAbort;
    e.words   = words;
    e.count   = count;
    expQ.push_back(e);
  endtask

  task automatic waitRead(input string name);
    int n = 0;
    while (readData !== 1'b1 && n < 64) begin
      tick(1);
      n++;
    end
    check(name, readData, 1);
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (packetDone !== 1'b1 && n < PW + 64) begin
      tick(1);
      n++;
    end
    check(name, packetDone, 1);
  endtask

  // Monitor: observes bursts and compares against the queued expectations.
  int   readsRun = 0, writesRun = 0, alignErr = 0, abortWait = 0;
  logic rdPrev1 = 0, rdPrev2 = 0, wrPrev1 = 0, errPrev = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge fx3_clock);
      if (!nReset) begin
        readsRun = 0; writesRun = 0; abortWait = 0;
        rdPrev1 = 0; rdPrev2 = 0; wrPrev1 = 0; errPrev = 0;
      end else begin
        if (fx3_write !== rdPrev2) alignErr++;
        if (readData && !rdPrev1) begin
          readsRun = 0;
          writesRun = 0;
        end
        if (readData) readsRun++;
        if (fx3_write) writesRun++;
        if (packetDone) begin
          if (expQ.size() == 0) begin
            check("unexpected_packetDone", 1, 0);
          end else begin
            e = expQ.pop_front();
            $display("packet done: reads=%0d writes=%0d count=%0d", readsRun, writesRun, packetCount);
            check("done_kind", 32'(packetDone & e.isAbort), 0);
            check("pkt_reads", readsRun, e.words);
            check("pkt_writes", writesRun, e.words);
            check("pkt_count", packetCount, e.count);
            check("pkt_write_align", alignErr, 0);
            check("done_after_last_write", {fx3_write, wrPrev1}, 2'b01);
          end
        end
        if (abortWait > 0) begin
          abortWait--;
          if (abortWait == 0) begin
            if (expQ.size() == 0) begin
              check("unexpected_abort", 1, 0);
            end else begin
              e = expQ.pop_front();
              $display("abort: reads=%0d writes=%0d count=%0d", readsRun, writesRun, packetCount);
              check("abort_kind", e.isAbort, 1);
              check("abort_reads", readsRun, e.words);
              check("abort_writes", writesRun, e.words);
              check("abort_count", packetCount, e.count);
              check("abort_write_align", alignErr, 0);
            end
          end
        end
        if (errorLatched && !errPrev) abortWait = LAT + 2;
        rdPrev2 = rdPrev1;
        rdPrev1 = readData;
        wrPrev1 = fx3_write;
        errPrev = errorLatched;
      end
    end
  end

  task automatic runAbort(input int word);
    dataAvailable = 1'b1;
    fx3_ready     = 1'b1;
    pushExp(1'b1, word, modelCount);
    waitRead("abort_start");
    tick(word - 1);
    bufferError = 1'b1;
    tick(1);
    bufferError   = 1'b0;
    dataAvailable = 1'b0;
    check("abort_read_drop", readData, 0);
    check("abort_latched", errorLatched, 1);
    check("abort_not_streaming", streaming, 0);
    tick(8);
    check("abort_count_held", packetCount, modelCount);
    check("abort_no_restart", readData, 0);
    collectData = 1'b0;
    tick(2);
    collectData = 1'b1;
    tick(1);
    modelCount = 0;
    check("clear_error", errorLatched, 0);
    check("clear_count", packetCount, modelCount);
  endtask

  initial begin
    int n;
    int w;
    nReset = 1'b0; collectData = 1'b0; dataAvailable = 1'b0;
    bufferError = 1'b0; fx3_ready = 1'b0;
    tick(3);
    check("reset_outputs", {readData, fx3_write, packetDone, streaming, errorLatched, packetCount}, 0);
    #2 nReset = 1'b1;
    tick(1);

    // Single packet with every condition met.
    collectData = 1'b1; dataAvailable = 1'b1; fx3_ready = 1'b1;
    modelCount++;
    pushExp(1'b0, PW, modelCount);
    waitRead("t1_start");
    dataAvailable = 1'b0;
    check("t1_streaming", streaming, 1);
    check("t1_write_not_yet", fx3_write, 0);
    tick(LAT);
    check("t1_write_latency", fx3_write, 1);
    waitDone("t1_done");
    n = 0;
    for (int i = 0; i < 20; i++) begin tick(1); n += int'(readData); end
    check("t1_idle_without_data", n, 0);

    // FX3 not ready: no reads until it is, then start on the next edge.
    fx3_ready = 1'b0; dataAvailable = 1'b1;
    w = $urandom_range(60, 150);
    n = 0;
    for (int i = 0; i < w; i++) begin tick(1); n += int'(readData); end
    check("t2_hold_off", n, 0);
    modelCount++;
    pushExp(1'b0, PW, modelCount);
    fx3_ready = 1'b1;
    tick(1);
    check("t2_start_next_edge", readData, 1);
    fx3_ready = 1'b0; dataAvailable = 1'b0;
    waitDone("t2_done");
    fx3_ready = 1'b1;

    // Aborts: mid-packet, and on the last-read edge.
    runAbort(4000);
    runAbort(PW);

    // Capture stop mid-packet: packet completes, then stays idle.
    dataAvailable = 1'b1;
    modelCount++;
    pushExp(1'b0, PW, modelCount);
    waitRead("t4_start");
    tick($urandom_range(2, 200) - 1);
    collectData = 1'b0;
    waitDone("t4_done");
    n = 0;
    for (int i = 0; i < 30; i++) begin tick(1); n += int'(readData); end
    check("t4_stays_idle", n, 0);

    // Back-to-back packets; new capture clears the count.
    collectData = 1'b1;
    modelCount = 0;
    pushExp(1'b0, PW, 1);
    pushExp(1'b0, PW, 2);
    modelCount = 2;
    waitDone("t5_done1");
    n = 0;
    while (readData !== 1'b1 && n < 64) begin tick(1); n++; end
    check("t5_gap_cycles", n, GAP + 1);
    dataAvailable = 1'b0;
    waitDone("t5_done2");

    // Asynchronous reset mid-stream, then a clean packet.
    dataAvailable = 1'b1;
    waitRead("t6_start");
    tick(49);
    #2 nReset = 1'b0;
    #1 check("t6_async_reset", {readData, fx3_write, packetDone, streaming, errorLatched, packetCount}, 0);
    dataAvailable = 1'b0;
    tick(2);
    #2 nReset = 1'b1;
    modelCount = 1;
    pushExp(1'b0, PW, modelCount);
    tick(1);
    dataAvailable = 1'b1;
    waitRead("t6_restart");
    dataAvailable = 1'b0;
    waitDone("t6_done");

    tick(10);
    check("scoreboard_drained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
